// File: rtl/getir_birimi.sv
// rtl/getir_birimi.sv - fetch stage: owns the PC, drives the cache request, buffers {PC, instr} for decode
module getir_birimi #(
  parameter logic [31:0] BASLANGIC_ADRESI = 32'h4000_0000,
  parameter int          TAMPON_DERINLIK  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dallanma_gecerli_i,
  input  logic [31:0] dallanma_adres_i,
  input  logic        cozme_durdur_i,
  input  logic [31:0] bbellek_buyruk_i,
  input  logic        bbellek_buyruk_hazir_i,
  output logic [31:0] bbellek_adres_o,
  output logic        bbellek_durdur_o,
  output logic        bbellek_ps_guncellendi_o,
  output logic [31:0] buyruk_o,
  output logic [31:0] buyruk_ps_o,
  output logic        buyruk_gecerli_o
);

  localparam int PW = (TAMPON_DERINLIK > 1) ? $clog2(TAMPON_DERINLIK) : 1;
  localparam int CW = $clog2(TAMPON_DERINLIK + 1);
  localparam logic [CW-1:0] DOLU    = CW'(TAMPON_DERINLIK);
  localparam logic [CW-1:0] ESIK    = CW'(TAMPON_DERINLIK - 1);
  localparam logic [PW-1:0] SON_IDX = PW'(TAMPON_DERINLIK - 1);

  logic [31:0]   r_pc;
  logic [31:0]   r_ps_mem     [TAMPON_DERINLIK];
  logic [31:0]   r_buyruk_mem [TAMPON_DERINLIK];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_bos;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_sonraki;
  logic [PW-1:0] w_rd_sonraki;

  // A redirect squashes both the arriving cache word and any decode pop.
  assign w_bos        = (r_count == '0);
  assign w_push       = bbellek_buyruk_hazir_i && !dallanma_gecerli_i && (r_count != DOLU);
  assign w_pop        = !w_bos && !cozme_durdur_i && !dallanma_gecerli_i;
  assign w_wr_sonraki = (r_wr_ptr == SON_IDX) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_sonraki = (r_rd_ptr == SON_IDX) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc     <= BASLANGIC_ADRESI;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (dallanma_gecerli_i) begin
      r_pc     <= {dallanma_adres_i[31:2], 2'b00};
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= w_wr_sonraki;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_sonraki;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && w_push) begin
      r_ps_mem[r_wr_ptr]     <= r_pc;
      r_buyruk_mem[r_wr_ptr] <= bbellek_buyruk_i;
    end
  end

  // Stall one entry early so a miss already in flight always has a slot to land in.
  assign bbellek_adres_o          = r_pc;
  assign bbellek_durdur_o         = !dallanma_gecerli_i && (r_count >= ESIK);
  assign bbellek_ps_guncellendi_o = rst_i && dallanma_gecerli_i;
  assign buyruk_gecerli_o         = !w_bos;
  assign buyruk_o                 = w_bos ? '0 : r_buyruk_mem[r_rd_ptr];
  assign buyruk_ps_o              = w_bos ? '0 : r_ps_mem[r_rd_ptr];

endmodule
